// File: rtl/ps2_kb_decoder.sv
// PS/2 keyboard receiver: sync, glitch filter, frame FSM, scan-code decode.
// Emits 12-bit {make, ext, 2'b00, code} words for kb_transmit.
module ps2_kb_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic        tx_clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] keyboard_data,
  output logic        key_event,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic          clk_s1;
  logic          clk_s2;
  logic          dat_s1;
  logic          dat_s2;
  logic          filt_clk;
  logic [FW-1:0] flt_cnt;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          ext;
  logic          brk;

  logic clk_new;
  logic flt_done;
  logic fall;
  logic tmo;
  logic frame_ok;

  assign clk_new  = clk_s2 != filt_clk;
  assign flt_done = clk_new && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall     = flt_done && filt_clk;
  assign tmo      = (state != IDLE) && !fall &&
                    (tcnt == TW'(TIMEOUT - 1));
  assign frame_ok = (^{shreg, par}) && dat_s2;

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      if (!clk_new) begin
        flt_cnt <= '0;
      end else if (flt_done) begin
        filt_clk <= clk_s2;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      par           <= 1'b0;
      tcnt          <= '0;
      ext           <= 1'b0;
      brk           <= 1'b0;
      keyboard_data <= '0;
      key_event     <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      key_event <= 1'b0;
      frame_err <= 1'b0;

      if (fall || state == IDLE)
        tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT))
        tcnt <= tcnt + TW'(1);

      unique case (state)
        IDLE: begin
          if (fall && !dat_s2) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (fall) begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
        end
        PARITY: begin
          if (fall) begin
            par   <= dat_s2;
            state <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state <= IDLE;
            if (!frame_ok) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end else begin
              unique case (shreg)
                8'hE0: ext <= 1'b1;
                8'hF0: brk <= 1'b1;
                8'h00, 8'hFF: begin
                  ext <= 1'b0;
                  brk <= 1'b0;
                end
                default: begin
                  keyboard_data <= {~brk, ext, 2'b00, shreg};
                  key_event     <= 1'b1;
                  ext           <= 1'b0;
                  brk           <= 1'b0;
                end
              endcase
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A stalled frame is dropped like a bad one
      if (tmo) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_kb_decoder.sv
// Bench for ps2_kb_decoder: frame table plus scoreboard of
// expected key_event / frame_err results.
module tb_ps2_kb_decoder;

  localparam int FL  = 4;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [11:0] keyboard_data;
  logic        key_event;
  logic        frame_err;

  ps2_kb_decoder #(
    .FILTER_LEN(FL),
    .TIMEOUT   (TMO)
  ) dut (
    .tx_clk       (clk),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .keyboard_data(keyboard_data),
    .key_event    (key_event),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    bit          bad_par;
    bit          bad_stop;
    bit          glitch;
    bit          exp_evt;
    bit          exp_err;
    logic [11:0] exp_kd;
  } vec_t;

  typedef struct {
    bit          is_err;
    logic [11:0] kd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int last_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(
    input logic [7:0] b, input bit bp, input bit bs,
    input bit g, input bit ev, input bit er,
    input logic [11:0] kd);
    vec_t v;
    v.b = b; v.bad_par = bp; v.bad_stop = bs;
    v.glitch = g; v.exp_evt = ev; v.exp_err = er;
    v.exp_kd = kd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (key_event || frame_err)) begin
      checks++;
      if (frame_err) last_err = cyc;
      if (key_event && frame_err) begin
        errors++;
        $display("FAIL both_pulses got 1/1 want exclusive");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse ev=%b err=%b kd=%h",
                 key_event, frame_err, keyboard_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_err != frame_err || keyboard_data !== e.kd) begin
          errors++;
          $display("FAIL pulse got err=%b kd=%h want err=%b kd=%h",
                   frame_err, keyboard_data, e.is_err, e.kd);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic glitch_pulse();
    ps2_clk = 1'b0;
    wait_cyc(FL - 1);
    ps2_clk = 1'b1;
    wait_cyc(8);
  endtask

  task automatic ps2_bit(input logic d, input bit g);
    ps2_data = d;
    wait_cyc(10);
    if (g) glitch_pulse();
    ps2_clk = 1'b0;
    last_fall = cyc;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send(input vec_t v);
    logic p;
    exp_t e;
    p = ~(^v.b) ^ v.bad_par;
    if (v.exp_evt || v.exp_err) begin
      e.is_err = v.exp_err;
      e.kd = v.exp_kd;
      sb.push_back(e);
    end
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      ps2_bit(v.b[i], v.glitch && i == 3);
    ps2_bit(p, 1'b0);
    ps2_bit(~v.bad_stop, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(30);
  endtask

  initial begin
    exp_t e;
    vecs.push_back(mk(8'h1C, 0, 0, 0, 1, 0, 12'h81C));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 12'h81C));
    vecs.push_back(mk(8'h1C, 0, 0, 0, 1, 0, 12'h01C));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 12'h01C));
    vecs.push_back(mk(8'h75, 0, 0, 0, 1, 0, 12'hC75));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 12'hC75));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 12'hC75));
    vecs.push_back(mk(8'h75, 0, 0, 0, 1, 0, 12'h475));
    vecs.push_back(mk(8'h1C, 1, 0, 0, 0, 1, 12'h475));
    vecs.push_back(mk(8'h1C, 0, 1, 0, 0, 1, 12'h475));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 12'h475));
    vecs.push_back(mk(8'h1C, 1, 0, 0, 0, 1, 12'h475));
    vecs.push_back(mk(8'h1C, 0, 0, 0, 1, 0, 12'h81C));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 12'h81C));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 0, 12'h81C));
    vecs.push_back(mk(8'h1C, 0, 0, 0, 1, 0, 12'h81C));
    vecs.push_back(mk(8'hFF, 0, 0, 0, 0, 0, 12'h81C));
    vecs.push_back(mk(8'h5A, 0, 0, 0, 1, 0, 12'h85A));
    vecs.push_back(mk(8'h29, 0, 0, 1, 1, 0, 12'h829));

    wait_cyc(5);
    chk("rst_kd", 32'(keyboard_data), 32'h000);
    chk("rst_ev", 32'(key_event), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_cyc(20);

    for (int i = 0; i < vecs.size(); i++)
      send(vecs[i]);

    // idle glitch with data low must not open a frame
    ps2_data = 1'b0;
    wait_cyc(5);
    glitch_pulse();
    ps2_data = 1'b1;
    wait_cyc(20);
    send(mk(8'h1C, 0, 0, 0, 1, 0, 12'h81C));

    // ext pending, then a stalled frame
    send(mk(8'hE0, 0, 0, 0, 0, 0, 12'h81C));
    e.is_err = 1'b1;
    e.kd = 12'h81C;
    sb.push_back(e);
    last_err = 0;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(TMO + 60);
    chk("tmo_delay", 32'(last_err - last_fall), 32'(TMO + FL + 2));
    send(mk(8'h1C, 0, 0, 0, 1, 0, 12'h81C));
    send(mk(8'h75, 0, 0, 0, 1, 0, 12'h875));

    // reset during parity bit of an E0-prefixed frame
    send(mk(8'hE0, 0, 0, 0, 0, 0, 12'h875));
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] c;
      c = 8'h1C;
      ps2_bit(c[i], 1'b0);
    end
    ps2_data = 1'b0;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(5);
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    chk("midrst_kd", 32'(keyboard_data), 32'h000);
    chk("midrst_ev", 32'(key_event), 32'h0);
    chk("midrst_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_cyc(TMO + 20);
    chk("post_rst_kd", 32'(keyboard_data), 32'h000);
    send(mk(8'h1C, 0, 0, 0, 1, 0, 12'h81C));

    wait_cyc(50);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("final_kd", 32'(keyboard_data), 32'h81C);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
